// File: rtl/mtl_pkg.sv
// Shared definitions for the MTL display path.
// Holds the RGB888 pixel type, the raster timing constants used by the
// controller and the scene renderer, the scene colours, and the state
// type of the renderer's ball shadow register.
package mtl_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned H_LINE    = 1056;
  localparam int unsigned V_LINE    = 525;
  localparam int unsigned H_OFFSET  = 45;
  localparam int unsigned V_OFFSET  = 23;
  localparam int unsigned H_ACTIVE  = 800;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned BALL_SIZE = 16;
  localparam int unsigned BORDER_W  = 4;

  localparam rgb_t BG_COLOR         = 24'h006400;
  localparam rgb_t BORDER_COLOR     = 24'h5C3317;
  localparam rgb_t BALL_RESET_COLOR = 24'hFFFFFF;

  // Shadow register for the host-supplied ball state.
  typedef enum logic {
    SH_EMPTY,
    SH_FULL
  } shadow_state_t;

endpackage

// File: rtl/mtl_scene_renderer_if.sv
// Host-side ball update channel of the scene renderer.
// Signals:
//   ball_x      ball left column, 0..1023
//   ball_y      ball top row, 0..511
//   ball_color  ball RGB888
//   ball_valid  host offers a new ball state
//   ball_ready  renderer shadow register is free
// The host drives the master modport, the renderer uses the slave modport.
interface mtl_scene_renderer_if ();

  logic [9:0]    ball_x;
  logic [8:0]    ball_y;
  mtl_pkg::rgb_t ball_color;
  logic          ball_valid;
  logic          ball_ready;

  modport master (
    output ball_x, ball_y, ball_color, ball_valid,
    input  ball_ready
  );

  modport slave (
    input  ball_x, ball_y, ball_color, ball_valid,
    output ball_ready
  );

endinterface

// File: rtl/mtl_raster_tracker.sv
// Raster position tracker for the scene renderer.
// Mirrors the display controller's x_cnt/y_cnt and exposes the position
// the controller will be at in the next cycle (lookahead), so that a
// registered colour stage lines up with the controller.
// Ports:
//   clk, rst_n    pixel clock, asynchronous active-low reset
//   new_frame     controller frame-start pulse (x_cnt==0 && y_cnt==0)
//   synced        tracking locked (set by first new_frame)
//   synced_next   lock state as of the next cycle
//   active_next   lookahead position lies in the active picture
//   px_next       lookahead column within the active picture
//   py_next       lookahead row within the active picture
module mtl_raster_tracker
  import mtl_pkg::*;
#(
  parameter int unsigned H_LINE   = mtl_pkg::H_LINE,
  parameter int unsigned V_LINE   = mtl_pkg::V_LINE,
  parameter int unsigned H_OFFSET = mtl_pkg::H_OFFSET,
  parameter int unsigned V_OFFSET = mtl_pkg::V_OFFSET,
  parameter int unsigned H_ACTIVE = mtl_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = mtl_pkg::V_ACTIVE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_frame,
  output logic       synced,
  output logic       synced_next,
  output logic       active_next,
  output logic [9:0] px_next,
  output logic [8:0] py_next
);

  logic [10:0] hc, hc_next;
  logic [9:0]  vc, vc_next;

  always_comb begin
    hc_next = hc + 11'd1;
    vc_next = vc;
    if (new_frame) begin
      // The pulse marks position (0,0) this cycle, so next is (1,0).
      hc_next = 11'd1;
      vc_next = '0;
    end else if (hc == 11'(H_LINE - 1)) begin
      hc_next = '0;
      vc_next = (vc == 10'(V_LINE - 1)) ? '0 : vc + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc     <= '0;
      vc     <= '0;
      synced <= 1'b0;
    end else begin
      hc <= hc_next;
      vc <= vc_next;
      if (new_frame) synced <= 1'b1;
    end
  end

  assign synced_next = synced | new_frame;

  assign active_next = (hc_next >= 11'(H_OFFSET)) && (hc_next < 11'(H_OFFSET + H_ACTIVE))
                    && (vc_next >= 10'(V_OFFSET)) && (vc_next < 10'(V_OFFSET + V_ACTIVE));

  // Only meaningful while active_next is set.
  assign px_next = 10'(hc_next - 11'(H_OFFSET));
  assign py_next = 9'(vc_next - 10'(V_OFFSET));

endmodule

// File: rtl/mtl_scene_renderer.sv
// Scene renderer: pixel source for the MTL display controller's iColorData.
// Paints a background and one square ball; the ball state arrives from the
// host over a valid/ready channel into a shadow register and is committed
// to the active register only at frame end, so a frame never tears.
// Ports:
//   iCLK, iRST_n  pixel clock, asynchronous active-low reset
//   iNewFrame     controller oNewFrame
//   iEndFrame     controller oEndFrame
//   ball          host ball channel (ball_x/y/color/valid in, ball_ready out)
//   oColorData    registered RGB888 to controller iColorData
//   oSynced       raster tracking locked
// Build option: define MTL_SCENE_BORDER_EN to paint a 4-pixel cushion
// border around the active picture; otherwise no border logic exists.
module mtl_scene_renderer
  import mtl_pkg::*;
#(
  parameter int unsigned H_LINE    = mtl_pkg::H_LINE,
  parameter int unsigned V_LINE    = mtl_pkg::V_LINE,
  parameter int unsigned H_OFFSET  = mtl_pkg::H_OFFSET,
  parameter int unsigned V_OFFSET  = mtl_pkg::V_OFFSET,
  parameter int unsigned H_ACTIVE  = mtl_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE  = mtl_pkg::V_ACTIVE,
  parameter int unsigned BALL_SIZE = mtl_pkg::BALL_SIZE
) (
  input  logic                        iCLK,
  input  logic                        iRST_n,
  input  logic                        iNewFrame,
  input  logic                        iEndFrame,
  mtl_scene_renderer_if.slave         ball,
  output logic [23:0]                 oColorData,
  output logic                        oSynced
);

  logic       synced_next;
  logic       active_next;
  logic [9:0] px_next;
  logic [8:0] py_next;

  mtl_raster_tracker #(
    .H_LINE   (H_LINE),
    .V_LINE   (V_LINE),
    .H_OFFSET (H_OFFSET),
    .V_OFFSET (V_OFFSET),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_tracker (
    .clk         (iCLK),
    .rst_n       (iRST_n),
    .new_frame   (iNewFrame),
    .synced      (oSynced),
    .synced_next (synced_next),
    .active_next (active_next),
    .px_next     (px_next),
    .py_next     (py_next)
  );

  shadow_state_t sh_state, sh_state_next;
  logic          capture, commit;

  logic [9:0] sh_x, act_x;
  logic [8:0] sh_y, act_y;
  rgb_t       sh_color, act_color;

  // A capture can only happen while empty and a commit only while full,
  // so a capture on the iEndFrame cycle naturally waits for the next one.
  always_comb begin
    sh_state_next = sh_state;
    capture       = 1'b0;
    commit        = 1'b0;
    case (sh_state)
      SH_EMPTY: begin
        if (ball.ball_valid) begin
          capture       = 1'b1;
          sh_state_next = SH_FULL;
        end
      end
      SH_FULL: begin
        if (iEndFrame) begin
          commit        = 1'b1;
          sh_state_next = SH_EMPTY;
        end
      end
      default: sh_state_next = SH_EMPTY;
    endcase
  end

  assign ball.ball_ready = (sh_state == SH_EMPTY);

  // Hit test in 11 bits so X+BALL_SIZE never wraps past 1023.
  logic [10:0] px_w, py_w, ball_x_w, ball_y_w;
  logic        ball_hit;
  rgb_t        pixel;

  assign px_w     = {1'b0, px_next};
  assign py_w     = {2'b0, py_next};
  assign ball_x_w = {1'b0, act_x};
  assign ball_y_w = {2'b0, act_y};
  assign ball_hit = (px_w >= ball_x_w) && (px_w < ball_x_w + 11'(BALL_SIZE))
                 && (py_w >= ball_y_w) && (py_w < ball_y_w + 11'(BALL_SIZE));

`ifdef MTL_SCENE_BORDER_EN
  logic border_hit;
  assign border_hit = (px_next < 10'(BORDER_W)) || (px_next >= 10'(H_ACTIVE - BORDER_W))
                   || (py_next < 9'(BORDER_W))  || (py_next >= 9'(V_ACTIVE - BORDER_W));
`endif

  always_comb begin
    pixel = '0;
    if (active_next) begin
      if (ball_hit) begin
        pixel = act_color;
`ifdef MTL_SCENE_BORDER_EN
      end else if (border_hit) begin
        pixel = BORDER_COLOR;
`endif
      end else begin
        pixel = BG_COLOR;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sh_state   <= SH_EMPTY;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_color   <= '0;
      act_x      <= '0;
      act_y      <= '0;
      act_color  <= BALL_RESET_COLOR;
      oColorData <= '0;
    end else begin
      sh_state <= sh_state_next;
      if (capture) begin
        sh_x     <= ball.ball_x;
        sh_y     <= ball.ball_y;
        sh_color <= ball.ball_color;
      end
      if (commit) begin
        act_x     <= sh_x;
        act_y     <= sh_y;
        act_color <= sh_color;
      end
      oColorData <= synced_next ? pixel : '0;
    end
  end

endmodule

// File: tb/tb_mtl_scene_renderer.sv
// Self-checking bench for mtl_scene_renderer with a shrunken raster so that
// many frames fit in a short run. A controller model produces the frame
// pulses; a pixel-level scene model predicts every output.
module tb_mtl_scene_renderer;

  localparam int HL = 76, VL = 32, HO = 10, VO = 5, HA = 64, VA = 24, BS = 16;
  localparam int FRAME = HL * VL;
  localparam logic [23:0] BG    = 24'h006400;
  localparam logic [23:0] BORD  = 24'h5C3317;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
`ifdef MTL_SCENE_BORDER_EN
  localparam logic [23:0] EDGE_C = BORD;
`else
  localparam logic [23:0] EDGE_C = BG;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        new_frame, end_frame;
  logic [23:0] color;
  logic        synced;

  mtl_scene_renderer_if bif ();

  mtl_scene_renderer #(
    .H_LINE(HL), .V_LINE(VL), .H_OFFSET(HO), .V_OFFSET(VO),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .BALL_SIZE(BS)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iNewFrame(new_frame), .iEndFrame(end_frame),
    .ball(bif), .oColorData(color), .oSynced(synced)
  );

  always #5 clk = ~clk;

  int checks, failures;

  // Controller position during the current cycle and pulse enable.
  int cx, cy;
  bit en;
  // Scene model.
  bit          m_synced, m_pending;
  int          act_x, act_y, sh_x, sh_y;
  logic [23:0] act_c, sh_c, exp_color;

  function automatic logic [23:0] pix(int x, int y, int bx, int by, logic [23:0] bc);
    int px, py;
    px = x - HO;
    py = y - VO;
    if (px < 0 || px >= HA || py < 0 || py >= VA) return 24'h0;
    if (px >= bx && px < bx + BS && py >= by && py < by + BS) return bc;
`ifdef MTL_SCENE_BORDER_EN
    if (px < 4 || px >= HA - 4 || py < 4 || py >= VA - 4) return BORD;
`endif
    return BG;
  endfunction

  function automatic logic [23:0] rnd_color();
    return 24'($urandom) | 24'h800000;
  endfunction

  task automatic model_reset();
    m_synced = 0; m_pending = 0;
    act_x = 0; act_y = 0; act_c = WHITE;
    sh_x = 0; sh_y = 0; sh_c = '0;
    exp_color = '0;
  endtask

  task automatic step();
    int nx, ny, bx, by;
    bit nf, cap, com, live;
    logic [23:0] bc;
    live = rst_n;
    nf  = new_frame;
    cap = bif.ball_valid && !m_pending;
    com = end_frame && m_pending;
    bx = int'(bif.ball_x); by = int'(bif.ball_y); bc = bif.ball_color;
    nx = cx + 1; ny = cy;
    if (nx == HL) begin nx = 0; ny = (cy + 1) % VL; end
    @(posedge clk);
    cx = nx; cy = ny;
    if (!live) begin
      model_reset();
    end else begin
      if (nf) m_synced = 1;
      exp_color = m_synced ? pix(nx, ny, act_x, act_y, act_c) : 24'h0;
      if (cap) begin sh_x = bx; sh_y = by; sh_c = bc; m_pending = 1; end
      if (com) begin act_x = sh_x; act_y = sh_y; act_c = sh_c; m_pending = 0; end
    end
    #1;
    new_frame = en && cx == 0 && cy == 0;
    end_frame = en && cx == HL - 1 && cy == VL - 1;
  endtask

  // Offers a ball state and waits until it is active at the start of a frame.
  task automatic load_ball(int x, int y, logic [23:0] c);
    int n;
    bif.ball_x = 10'(x); bif.ball_y = 9'(y); bif.ball_color = c; bif.ball_valid = 1'b1;
    n = 0;
    while (bif.ball_ready !== 1'b1 && n < 2 * FRAME) begin step(); n++; end
    step();
    bif.ball_valid = 1'b0;
    n = 0;
    while (!(cx == 0 && cy == 0 && !m_pending) && n < 3 * FRAME) begin step(); n++; end
    checks++;
    if (bif.ball_ready !== 1'b1 || m_pending) begin
      failures++;
      $display("FAIL load_ball_commit got_ready=%b required=1", bif.ball_ready);
    end
  endtask

  task automatic test_reset();
    #22;
    checks++; if (color !== 24'h0) begin failures++; $display("FAIL reset_color got=%h required=0", color); end
    checks++; if (synced !== 1'b0) begin failures++; $display("FAIL reset_synced got=%b required=0", synced); end
    checks++; if (bif.ball_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", bif.ball_ready); end
    rst_n = 1'b1;
    repeat (2000) begin
      step();
      checks++; if (synced !== 1'b0) begin failures++; $display("FAIL nosync_synced got=%b required=0", synced); end
      checks++; if (color !== 24'h0) begin failures++; $display("FAIL nosync_color got=%h required=0", color); end
    end
  endtask

  task automatic test_first_frame();
    int n;
    logic [23:0] ca;
    ca = rnd_color();
    en = 1;
    n = 0;
    while (synced !== 1'b1 && n < FRAME + 4) begin
      step(); n++;
      checks++; if (color !== exp_color) begin failures++; $display("FAIL presync_color got=%h required=%h", color, exp_color); end
    end
    checks++; if (synced !== 1'b1) begin failures++; $display("FAIL first_sync got=%b required=1", synced); end
    load_ball(20, 6, ca);
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (color !== exp_color) begin failures++; $display("FAIL frame_color x=%0d y=%0d got=%h required=%h", cx, cy, color, exp_color); end
      if (cx == HO + 20 && cy == VO + 6) begin
        checks++; if (color !== ca) begin failures++; $display("FAIL ball_corner got=%h required=%h", color, ca); end
      end
      if (cx == HO + 19 && cy == VO + 6) begin
        checks++; if (color !== BG) begin failures++; $display("FAIL left_of_ball got=%h required=%h", color, BG); end
      end
      if (cx == HO + HA - 1 && cy == VO + VA - 1) begin
        checks++; if (color !== EDGE_C) begin failures++; $display("FAIL last_active got=%h required=%h", color, EDGE_C); end
      end
      if (cx == HO + HA && cy == VO + VA - 1) begin
        checks++; if (color !== 24'h0) begin failures++; $display("FAIL past_active got=%h required=0", color); end
      end
    end
  endtask

  task automatic test_mid_frame_write();
    int n;
    logic [23:0] old_c, c3;
    old_c = act_c;
    c3 = rnd_color();
    n = 0;
    while (!(cx == 0 && cy == VO + 10) && n < FRAME) begin step(); n++; end
    bif.ball_x = 10'd40; bif.ball_y = 9'd4; bif.ball_color = c3; bif.ball_valid = 1'b1;
    step();
    bif.ball_valid = 1'b0;
    checks++; if (bif.ball_ready !== 1'b0) begin failures++; $display("FAIL midwrite_ready_drop got=%b required=0", bif.ball_ready); end
    n = 0;
    while (!(cx == 0 && cy == 0) && n < FRAME) begin
      step(); n++;
      checks++; if (color !== exp_color) begin failures++; $display("FAIL pending_color got=%h required=%h", color, exp_color); end
      checks++; if (bif.ball_ready !== !m_pending) begin failures++; $display("FAIL pending_ready got=%b required=%b", bif.ball_ready, !m_pending); end
      if (cx == HO + 44 && cy == VO + 12) begin
        checks++; if (color !== BG) begin failures++; $display("FAIL no_tear_new got=%h required=%h", color, BG); end
      end
      if (cx == HO + 20 && cy == VO + 12) begin
        checks++; if (color !== old_c) begin failures++; $display("FAIL no_tear_old got=%h required=%h", color, old_c); end
      end
    end
    checks++; if (bif.ball_ready !== 1'b1) begin failures++; $display("FAIL ready_reassert got=%b required=1", bif.ball_ready); end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (color !== exp_color) begin failures++; $display("FAIL moved_color got=%h required=%h", color, exp_color); end
      if (cx == HO + 44 && cy == VO + 12) begin
        checks++; if (color !== c3) begin failures++; $display("FAIL moved_new got=%h required=%h", color, c3); end
      end
      if (cx == HO + 20 && cy == VO + 12) begin
        checks++; if (color !== BG) begin failures++; $display("FAIL moved_old got=%h required=%h", color, BG); end
      end
    end
  endtask

  task automatic test_end_frame_capture();
    int n;
    logic [23:0] ca, cb;
    ca = rnd_color(); cb = rnd_color();
    n = 0;
    while (end_frame !== 1'b1 && n < FRAME + 2) begin step(); n++; end
    bif.ball_x = 10'd8; bif.ball_y = 9'd2; bif.ball_color = ca; bif.ball_valid = 1'b1;
    step();
    bif.ball_valid = 1'b0;
    checks++; if (bif.ball_ready !== 1'b0) begin failures++; $display("FAIL coincident_ready got=%b required=0", bif.ball_ready); end
    repeat (100) begin
      step();
      checks++; if (color !== exp_color) begin failures++; $display("FAIL deferred_color got=%h required=%h", color, exp_color); end
    end
    bif.ball_x = 10'd40; bif.ball_y = 9'd10; bif.ball_color = cb; bif.ball_valid = 1'b1;
    repeat (20) begin
      step();
      checks++; if (bif.ball_ready !== 1'b0) begin failures++; $display("FAIL ignored_ready got=%b required=0", bif.ball_ready); end
    end
    bif.ball_valid = 1'b0;
    n = 0;
    while (!(cx == 0 && cy == 0) && n < FRAME) begin
      step(); n++;
      checks++; if (color !== exp_color) begin failures++; $display("FAIL deferred_color got=%h required=%h", color, exp_color); end
      if (cx == HO + 12 && cy == VO + 8) begin
        checks++; if (color !== BG) begin failures++; $display("FAIL deferred_not_shown got=%h required=%h", color, BG); end
      end
    end
    checks++; if (bif.ball_ready !== 1'b1) begin failures++; $display("FAIL deferred_commit_ready got=%b required=1", bif.ball_ready); end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (color !== exp_color) begin failures++; $display("FAIL committed_color got=%h required=%h", color, exp_color); end
      if (cx == HO + 12 && cy == VO + 8) begin
        checks++; if (color !== ca) begin failures++; $display("FAIL committed_first got=%h required=%h", color, ca); end
      end
      if (cx == HO + 44 && cy == VO + 12) begin
        checks++; if (color !== BG) begin failures++; $display("FAIL second_write_dropped got=%h required=%h", color, BG); end
      end
    end
  endtask

  task automatic test_edge_ball();
    int hits;
    logic [23:0] ce;
    ce = rnd_color();
    load_ball(HA - 8, VA - 4, ce);
    hits = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (color === ce) hits++;
      checks++; if (color !== exp_color) begin failures++; $display("FAIL clip_color got=%h required=%h", color, exp_color); end
    end
    checks++; if (hits != 32) begin failures++; $display("FAIL clip_pixel_count got=%0d required=32", hits); end
    load_ball(HA, 0, ce);
    hits = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (color === ce) hits++;
      checks++; if (color !== exp_color) begin failures++; $display("FAIL offscreen_color got=%h required=%h", color, exp_color); end
    end
    checks++; if (hits != 0) begin failures++; $display("FAIL offscreen_pixel_count got=%0d required=0", hits); end
  endtask

  task automatic test_random();
    bit took;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (!bif.ball_valid && $urandom_range(0, 299) == 0) begin
        bif.ball_x = 10'($urandom_range(0, HA + 8));
        bif.ball_y = 9'($urandom_range(0, VA + 4));
        bif.ball_color = rnd_color();
        bif.ball_valid = 1'b1;
      end
      took = bif.ball_valid && bif.ball_ready;
      step();
      if (took) bif.ball_valid = 1'b0;
      checks++; if (color !== exp_color) begin failures++; $display("FAIL random_color x=%0d y=%0d got=%h required=%h", cx, cy, color, exp_color); end
      checks++; if (bif.ball_ready !== !m_pending) begin failures++; $display("FAIL random_ready got=%b required=%b", bif.ball_ready, !m_pending); end
    end
    bif.ball_valid = 1'b0;
  endtask

  task automatic test_reset_mid_line();
    int n;
    n = 0;
    while (!(cx == 30 && cy == VO + 3) && n < 2 * FRAME) begin step(); n++; end
    while (bif.ball_ready !== 1'b1 && n < 4 * FRAME) begin step(); n++; end
    bif.ball_x = 10'd30; bif.ball_y = 9'd10; bif.ball_color = rnd_color(); bif.ball_valid = 1'b1;
    step();
    bif.ball_valid = 1'b0;
    checks++; if (bif.ball_ready !== 1'b0) begin failures++; $display("FAIL pre_reset_pending got=%b required=0", bif.ball_ready); end
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (color !== 24'h0) begin failures++; $display("FAIL async_reset_color got=%h required=0", color); end
    checks++; if (synced !== 1'b0) begin failures++; $display("FAIL async_reset_synced got=%b required=0", synced); end
    checks++; if (bif.ball_ready !== 1'b1) begin failures++; $display("FAIL async_reset_ready got=%b required=1", bif.ball_ready); end
    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
    while (synced !== 1'b1 && n < FRAME + 4) begin
      step(); n++;
      checks++; if (color !== 24'h0) begin failures++; $display("FAIL resync_wait_color got=%h required=0", color); end
    end
    checks++; if (synced !== 1'b1) begin failures++; $display("FAIL resync got=%b required=1", synced); end
    for (int i = 0; i < FRAME; i++) begin
      step();
      checks++; if (color !== exp_color) begin failures++; $display("FAIL after_reset_color got=%h required=%h", color, exp_color); end
      if (cx == HO + 2 && cy == VO + 2) begin
        checks++; if (color !== WHITE) begin failures++; $display("FAIL reset_ball got=%h required=%h", color, WHITE); end
      end
      if (cx == HO + 34 && cy == VO + 14) begin
        checks++; if (color !== BG) begin failures++; $display("FAIL discarded_shadow got=%h required=%h", color, BG); end
      end
    end
    checks++; if (bif.ball_ready !== 1'b1) begin failures++; $display("FAIL after_reset_ready got=%b required=1", bif.ball_ready); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; new_frame = 1'b0; end_frame = 1'b0;
    en = 0; cx = 0; cy = 0;
    bif.ball_x = '0; bif.ball_y = '0; bif.ball_color = '0; bif.ball_valid = 1'b0;
    model_reset();
    test_reset();
    test_first_frame();
    test_mid_frame_write();
    test_end_frame_capture();
    test_edge_ball();
    test_random();
    test_reset_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
